// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between instruction fetch and data access.
// One access is outstanding at a time; done pulses and read data are registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifDone,
  output logic              ifStall,
  input  logic              dmRd,
  input  logic              dmWr,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [DATA_W-1:0] dmWdata,
  output logic [DATA_W-1:0] dmRdata,
  output logic              dmDone,
  output logic              dmStall,
  output logic              err,
  output logic              memEn,
  output logic              memWr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memDone,
  input  logic [DATA_W-1:0] memRdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic                last_data_q, last_data_d;
  logic                own_data_q, own_data_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic                err_q, err_d;
  logic                mem_en;

  logic dm_req;
  logic dm_illegal;
  logic grant_data;
  logic grant_fetch;
  logic owner_held;

  // Read and write together is not a data request; it only raises err.
  assign dm_req      = dmRd ^ dmWr;
  assign dm_illegal  = dmRd & dmWr;
  assign grant_data  = dm_req & (~ifReq | ~last_data_q);
  assign grant_fetch = ifReq & ~grant_data;

  // A requester that dropped its request by memDone gets no done pulse.
  assign owner_held  = own_data_q ? (op_wr_q ? dmWr : dmRd) : ifReq;

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    own_data_d  = own_data_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = 1'b0;
    mem_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        err_d = dm_illegal;
        if (grant_data || grant_fetch) begin
          state_d     = StIssue;
          own_data_d  = grant_data;
          last_data_d = grant_data;
          op_wr_d     = grant_data & dmWr;
          addr_d      = grant_data ? dmAddr : ifAddr;
          wdata_d     = grant_data ? dmWdata : '0;
        end
      end
      StIssue: begin
        mem_en  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (memDone) begin
          state_d = StIdle;
          if (owner_held) begin
            if (own_data_q) begin
              dm_done_d = 1'b1;
              if (!op_wr_q) begin
                dm_rdata_d = memRdata;
              end
            end else begin
              if_done_d  = 1'b1;
              if_rdata_d = memRdata;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_data_q <= 1'b0;
      own_data_q  <= 1'b0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      own_data_q  <= own_data_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
    end
  end

  // Command fields are zeroed outside the issue cycle so the bus idles clean.
  assign memEn    = mem_en;
  assign memWr    = mem_en & op_wr_q;
  assign memAddr  = mem_en ? addr_q : '0;
  assign memWdata = mem_en ? wdata_q : '0;

  assign ifRdata  = if_rdata_q;
  assign ifDone   = if_done_q;
  assign dmRdata  = dm_rdata_q;
  assign dmDone   = dm_done_q;
  assign err      = err_q;
  assign ifStall  = ifReq & ~if_done_q;
  assign dmStall  = (dmRd | dmWr) & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic against a
// transaction-level model (busy flag, last grant, completion timestamps).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, ifReq, dmRd, dmWr, memDone;
  logic [15:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [15:0] ifRdata, dmRdata, memAddr, memWdata;
  logic        ifDone, ifStall, dmDone, dmStall, err, memEn, memWr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone), .ifStall(ifStall),
    .dmRd(dmRd), .dmWr(dmWr), .dmAddr(dmAddr), .dmWdata(dmWdata), .dmRdata(dmRdata),
    .dmDone(dmDone), .dmStall(dmStall), .err(err),
    .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memWdata(memWdata),
    .memDone(memDone), .memRdata(memRdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model
  bit          busy, own_data, op_wr, last_data;
  int          en_cycle;
  bit          e_memEn, e_ifDone, e_dmDone, e_err, e_memWr;
  logic [15:0] e_ifRdata, e_dmRdata, e_memAddr, e_memWdata;

  // Memory responder
  int          mem_done_at = -1;
  logic [15:0] mem_data, fixed_data;
  bit          rnd_mode = 1'b0;
  bit          spur_en  = 1'b0;
  logic [15:0] grants[$];

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy = 0; own_data = 0; op_wr = 0; last_data = 0; en_cycle = -10;
    e_memEn = 0; e_ifDone = 0; e_dmDone = 0; e_err = 0; e_memWr = 0;
    e_ifRdata = '0; e_dmRdata = '0; e_memAddr = '0; e_memWdata = '0;
  endtask

  // One clock cycle: inputs already set by caller; check outputs, advance model.
  task automatic tick();
    bit          n_en, n_ifD, n_dmD, n_err, held, dreq, gdata;
    logic [15:0] n_ifR, n_dmR;
    memDone  = (cyc == mem_done_at);
    memRdata = memDone ? mem_data : 16'($urandom);
    if (spur_en && !memDone && !(busy && cyc > en_cycle) && $urandom_range(0, 7) == 0)
      memDone = 1'b1;
    #1;
    check1("memEn", memEn, e_memEn);
    if (e_memEn) begin
      check1("memWr", memWr, e_memWr);
      check16("memAddr", memAddr, e_memAddr);
      if (e_memWr) check16("memWdata", memWdata, e_memWdata);
    end
    check1("ifDone", ifDone, e_ifDone);
    check1("dmDone", dmDone, e_dmDone);
    check1("err", err, e_err);
    check16("ifRdata", ifRdata, e_ifRdata);
    check16("dmRdata", dmRdata, e_dmRdata);
    check1("ifStall", ifStall, ifReq & ~e_ifDone);
    check1("dmStall", dmStall, (dmRd | dmWr) & ~e_dmDone);
    if (memEn) grants.push_back(memAddr);

    n_en = 0; n_ifD = 0; n_dmD = 0; n_err = 0;
    n_ifR = e_ifRdata; n_dmR = e_dmRdata;
    if (rst) begin
      busy = 0; last_data = 0; n_ifR = '0; n_dmR = '0;
    end else if (busy && cyc > en_cycle) begin
      if (memDone) begin
        busy = 0;
        held = own_data ? (op_wr ? dmWr : dmRd) : ifReq;
        if (held && own_data) begin
          n_dmD = 1;
          if (!op_wr) n_dmR = memRdata;
        end else if (held) begin
          n_ifD = 1;
          n_ifR = memRdata;
        end
      end
    end else if (!busy) begin
      dreq  = dmRd ^ dmWr;
      n_err = dmRd & dmWr;
      gdata = dreq && (!ifReq || !last_data);
      if (gdata || ifReq) begin
        busy = 1; own_data = gdata; last_data = gdata; en_cycle = cyc + 1; n_en = 1;
        op_wr = gdata && dmWr;
        e_memWr = op_wr;
        e_memAddr = gdata ? dmAddr : ifAddr;
        e_memWdata = dmWdata;
      end
    end
    e_memEn = n_en; e_ifDone = n_ifD; e_dmDone = n_dmD; e_err = n_err;
    e_ifRdata = n_ifR; e_dmRdata = n_dmR;

    if (memEn) begin
      mem_done_at = cyc + (rnd_mode ? int'($urandom_range(1, 4)) : 3);
      mem_data    = rnd_mode ? 16'($urandom) : fixed_data;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input bit data_side, input int bound, input string tag);
    int n = 0;
    while (!(data_side ? e_dmDone : e_ifDone) && n < bound) begin
      tick();
      n++;
    end
    check1(tag, n < bound, 1'b1);
  endtask

  task automatic new_dm();
    bit wr = 1'($urandom_range(0, 1));
    dmRd = !wr; dmWr = wr; dmAddr = 16'($urandom); dmWdata = 16'($urandom);
  endtask

  task automatic drive_random();
    int r;
    rst = ($urandom_range(0, 399) == 0);
    if (ifReq) begin
      if (e_ifDone) begin
        if ($urandom_range(0, 1) == 0) ifReq = 0;
        else ifAddr = 16'($urandom);
      end else if (busy && !own_data && $urandom_range(0, 9) == 0) ifReq = 0;
    end else if (!(busy && !own_data) && $urandom_range(0, 2) == 0) begin
      ifReq = 1; ifAddr = 16'($urandom);
    end
    if (dmRd && dmWr) begin
      dmRd = 0; dmWr = 0;
    end else if (dmRd || dmWr) begin
      if (e_dmDone) begin
        if ($urandom_range(0, 1) == 0) begin dmRd = 0; dmWr = 0; end
        else new_dm();
      end else if (busy && own_data && $urandom_range(0, 15) == 0) begin
        dmRd = 0; dmWr = 0;
      end
    end else if (!(busy && own_data)) begin
      r = int'($urandom_range(0, 11));
      if (r < 3) new_dm();
      else if (r == 3) begin dmRd = 1; dmWr = 1; dmAddr = 16'($urandom); end
    end
  endtask

  initial begin
    int t0, ifd;
    rst = 1; ifReq = 0; dmRd = 0; dmWr = 0; memDone = 0;
    ifAddr = '0; dmAddr = '0; dmWdata = '0; memRdata = '0; fixed_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_memEn", memEn, 1'b0);
    check1("rst_memWr", memWr, 1'b0);
    check16("rst_memAddr", memAddr, 16'h0);
    check16("rst_memWdata", memWdata, 16'h0);
    check16("rst_ifRdata", ifRdata, 16'h0);
    check16("rst_dmRdata", dmRdata, 16'h0);
    check1("rst_ifDone", ifDone, 1'b0);
    check1("rst_dmDone", dmDone, 1'b0);
    check1("rst_err", err, 1'b0);
    model_reset();
    rst = 0;

    // Single fetch
    fixed_data = 16'hC0DE; ifReq = 1; ifAddr = 16'h0010; t0 = cyc;
    run_until(0, 12, "fetch_done");
    check16("fetch_rdata", ifRdata, 16'hC0DE);
    check16("fetch_latency", 16'(cyc - t0), 16'd5);
    check1("fetch_stall_done", ifStall, 1'b0);
    ifReq = 0; tick(); tick();

    // Data write leaves dmRdata alone
    fixed_data = 16'hFFFF; grants.delete();
    dmWr = 1; dmAddr = 16'h2000; dmWdata = 16'h1234;
    run_until(1, 12, "write_done");
    check16("write_rdata_kept", dmRdata, 16'h0);
    check16("write_grants", 16'(grants.size()), 16'd1);
    if (grants.size() > 0) check16("write_addr", grants[0], 16'h2000);
    dmWr = 0; tick();

    // Conflict after reset: D, I, D, I
    rst = 1; tick(); rst = 0;
    fixed_data = 16'h5A5A; grants.delete();
    ifReq = 1; ifAddr = 16'h0100; dmRd = 1; dmAddr = 16'h0200;
    repeat (30) tick();
    check1("conflict_count", grants.size() >= 4, 1'b1);
    if (grants.size() >= 4)
      for (int i = 0; i < 4; i++)
        check16($sformatf("conflict_grant%0d", i), grants[i], (i % 2 == 0) ? 16'h0200 : 16'h0100);
    ifReq = 0; dmRd = 0;
    repeat (8) tick();

    // Fetch flush with pending data read
    fixed_data = 16'hBEEF; ifd = 0;
    ifReq = 1; ifAddr = 16'h0300; tick();
    dmRd = 1; dmAddr = 16'h0400; tick();
    ifReq = 0;
    for (int n = 0; n < 20 && !e_dmDone; n++) begin
      tick();
      if (ifDone) ifd++;
    end
    check16("flush_no_ifdone", 16'(ifd), 16'd0);
    check1("flush_ifrdata_kept", ifRdata == 16'hBEEF, 1'b0);
    check16("flush_dm_rdata", dmRdata, 16'hBEEF);
    dmRd = 0; tick();

    // Illegal read+write
    dmRd = 1; dmWr = 1; dmAddr = 16'h0600; tick();
    dmRd = 0; dmWr = 0;
    check1("illegal_err", err, 1'b1);
    check1("illegal_no_memen", memEn, 1'b0);
    tick();
    check1("illegal_err_once", err, 1'b0);
    tick();
    check1("illegal_no_memen2", memEn, 1'b0);

    // Reset during WAIT, late memDone ignored
    fixed_data = 16'h7777;
    ifReq = 1; ifAddr = 16'h0500; tick(); tick(); tick();
    rst = 1; tick();
    rst = 0; ifReq = 0; tick(); tick();
    check1("rstwait_ifDone", ifDone, 1'b0);
    check1("rstwait_memEn", memEn, 1'b0);
    check16("rstwait_ifRdata", ifRdata, 16'h0);
    check16("rstwait_dmRdata", dmRdata, 16'h0);
    grants.delete();
    ifReq = 1; ifAddr = 16'h0700; dmRd = 1; dmAddr = 16'h0800;
    run_until(1, 20, "post_reset_dm_done");
    if (grants.size() > 0) check16("post_reset_first", grants[0], 16'h0800);
    dmRd = 0;
    run_until(0, 20, "post_reset_if_done");
    ifReq = 0; tick(); tick();

    // Random traffic
    rnd_mode = 1; spur_en = 1; grants.delete();
    repeat (3000) begin
      drive_random();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single unified memory port between the instruction-fetch requester and the data-memory requester of the pipelined 16-bit processor. It owns one outstanding memory access at a time, drives the memory command, returns read data to the owner, and generates the fetch and data stall signals the pipeline control uses. Data requests win conflicts unless the previous grant was also data, in which case fetch goes first.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifReq  in  1  fetch read request, held until ifDone or dropped
- ifAddr  in  ADDR_W  fetch address
- ifRdata  out  DATA_W  fetch read data, valid when ifDone=1
- ifDone  out  1  one-cycle completion pulse for fetch
- ifStall  out  1  ifReq & ~ifDone
- dmRd  in  1  data read request
- dmWr  in  1  data write request
- dmAddr  in  ADDR_W  data address
- dmWdata  in  DATA_W  data write value
- dmRdata  out  DATA_W  data read value, valid when dmDone=1 after a read
- dmDone  out  1  one-cycle completion pulse for data
- dmStall  out  1  (dmRd|dmWr) & ~dmDone
- err  out  1  one-cycle pulse: dmRd and dmWr both high in IDLE
- memEn  out  1  memory command strobe, exactly one cycle per access
- memWr  out  1  1 = write, 0 = read; valid with memEn
- memAddr  out  ADDR_W  command address; valid with memEn
- memWdata  out  DATA_W  command write data; valid with memEn
- memDone  in  1  memory completion, earliest the cycle after memEn
- memRdata  in  DATA_W  memory read data, valid with memDone

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: evaluate requests. Data request = dmRd ^ dmWr; dmRd & dmWr pulses err next cycle and counts as no data request. Fetch request = ifReq.
- Selection: only one pending -> it wins. Both pending -> data wins unless lastGrant=DATA, then fetch wins. On selection, latch owner, op, address, wdata; update lastGrant; go ISSUE.
- ISSUE: memEn=1 with latched memWr/memAddr/memWdata; go WAIT.
- WAIT: hold until memDone. On memDone: latch memRdata into owner's rdata register, set owner's done for next cycle, go IDLE.
- Dropped request: if owner's request is deasserted by the memDone cycle (fetch flush), the access completes on the memory side but the done pulse is suppressed and rdata is not updated.
- memDone outside WAIT is ignored.
- Writes: dmDone pulses, dmRdata keeps its previous value.
- Requester contract: address/data stable while request high; after its done pulse, a requester may hold request high for a new access, which re-enters arbitration in the IDLE cycle coinciding with the done pulse.
- Reset: state IDLE, lastGrant=FETCH (first conflict goes to data), memEn=memWr=0, memAddr=memWdata=0, ifRdata=dmRdata=0, ifDone=dmDone=err=0. Reset during ISSUE/WAIT abandons the access; no done pulse; a later memDone is ignored.

## Timing
- Request sampled in IDLE at cycle t; memEn at t+1; memDone earliest t+2; done pulse and rdata at cycle after memDone (earliest t+3).
- Done and rdata registered; stall outputs combinational from request and done.
- Back-to-back: done cycle is an IDLE cycle, so next memEn is 2 cycles after the previous memDone (one-cycle arbitration bubble).
- Starvation bound: with both requesters continuously requesting, grants alternate D, I, D, I.
- memEn never asserted in two consecutive cycles.

## Test plan
- Single fetch: ifReq=1, ifAddr=0x0010, memory memDone 3 cycles after memEn with 0xC0DE -> memEn 1 cycle, memWr=0, memAddr=0x0010; ifDone pulses one cycle later with ifRdata=0xC0DE; ifStall high until then.
- Data write: dmWr=1, dmAddr=0x2000, dmWdata=0x1234 -> memEn, memWr=1, memAddr=0x2000, memWdata=0x1234; dmDone pulses; dmRdata unchanged.
- Conflict after reset: ifReq and dmRd both high, held -> first grant data, then fetch, then data; never two consecutive grants to the same requester while both pending.
- Fetch flush: fetch granted, ifReq dropped while in WAIT, memDone with 0xBEEF -> no ifDone pulse, ifRdata unchanged; pending dmRd granted next IDLE.
- Illegal op: dmRd=dmWr=1, ifReq=0 -> err pulses one cycle, no memEn.
- Reset mid-access: rst in WAIT, then memDone arrives -> no done pulses, all outputs 0, subsequent ifReq serviced normally with data priority on conflict.
